// File: rtl/trig_sync_pkg.sv
// ============================================================================
// trig_sync_pkg
// Shared types and constants for the multi-channel trigger synchronizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package trig_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } ch_state_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PW_W  = 4;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/trig_sync_ch.sv
// ============================================================================
// trig_sync_ch
// One trigger channel: arm/disarm FSM, edge counter and pulse-width timer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trig_sync_ch
    import trig_sync_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PW_W  = DEF_PW_W
) (
    input  logic             sysClk,
    input  logic             reset,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic             tedge_i,
    input  logic [CNT_W-1:0] skip_cnt_i,
    input  logic [PW_W-1:0]  pulse_w_i,
    input  logic             cont_i,
    output logic             sync_o,
    output logic             armed_o,
    output logic             done_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] skip_q,  skip_d;
    logic [PW_W-1:0]  pw_q,    pw_d;
    logic [PW_W-1:0]  pwcnt_q, pwcnt_d;
    logic             cont_q,  cont_d;
    logic             done_q,  done_d;
    logic [PW_W-1:0]  pw_load;

    // A programmed width of 0 behaves as a single-cycle pulse.
    assign pw_load = (pw_q == '0) ? '0 : pw_q - PW_W'(1);

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            skip_q  <= '0;
            pw_q    <= '0;
            pwcnt_q <= '0;
            cont_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            pw_q    <= pw_d;
            pwcnt_q <= pwcnt_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        skip_d  = skip_q;
        pw_d    = pw_q;
        pwcnt_d = pwcnt_q;
        cont_d  = cont_q;
        done_d  = done_q;

        // Disarm takes priority over everything, including a same-cycle arm.
        if (disarm_i) begin
            state_d = IDLE;
            count_d = '0;
            pwcnt_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        skip_d  = skip_cnt_i;
                        pw_d    = pulse_w_i;
                        cont_d  = cont_i;
                        count_d = '0;
                        done_d  = 1'b0;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (arm_i) begin
                        skip_d  = skip_cnt_i;
                        pw_d    = pulse_w_i;
                        cont_d  = cont_i;
                        count_d = '0;
                        done_d  = 1'b0;
                    end else if (tedge_i) begin
                        if (count_q == skip_q) begin
                            state_d = FIRE;
                            pwcnt_d = pw_load;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                FIRE: begin
                    if (pwcnt_q == '0) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        state_d = (cont_q == MODE_CONT) ? ARMED : IDLE;
                    end else begin
                        pwcnt_d = pwcnt_q - PW_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign sync_o  = (state_q == FIRE);
    assign armed_o = (state_q == ARMED);
    assign done_o  = done_q;

endmodule

`default_nettype wire

// File: rtl/trig_sync_arm.sv
// ============================================================================
// trig_sync_arm
// Shared trigger edge detector fanned out to N_CH armable sync channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trig_sync_arm
    import trig_sync_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PW_W  = DEF_PW_W
) (
    input  logic             sysClk,
    input  logic             reset,
    input  logic [N_CH-1:0]  arm_i,
    input  logic [N_CH-1:0]  disarm_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] skip_cnt_i,
    input  logic [PW_W-1:0]  pulse_w_i,
    input  logic [N_CH-1:0]  cont_i,
    output logic [N_CH-1:0]  sync_o,
    output logic [N_CH-1:0]  armed_o,
    output logic [N_CH-1:0]  done_o
);

    logic trig_q;
    logic tedge;

    // Resetting to 1 keeps a trigger held high through reset from looking like an edge.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            trig_q <= 1'b1;
        end else begin
            trig_q <= trig_i;
        end
    end

    assign tedge = trig_i & ~trig_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        trig_sync_ch #(
            .CNT_W (CNT_W),
            .PW_W  (PW_W)
        ) u_ch (
            .sysClk     (sysClk),
            .reset      (reset),
            .arm_i      (arm_i[g]),
            .disarm_i   (disarm_i[g]),
            .tedge_i    (tedge),
            .skip_cnt_i (skip_cnt_i),
            .pulse_w_i  (pulse_w_i),
            .cont_i     (cont_i[g]),
            .sync_o     (sync_o[g]),
            .armed_o    (armed_o[g]),
            .done_o     (done_o[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_sync_arm.sv
// ============================================================================
// tb_trig_sync_arm
// Scoreboard bench: a behavioural channel model queues expected outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trig_sync_arm;

    localparam int N = 4;

    logic         sysClk = 1'b0;
    logic         reset;
    logic [N-1:0] arm_i, disarm_i, cont_i;
    logic         trig_i;
    logic [7:0]   skip_cnt_i;
    logic [3:0]   pulse_w_i;
    logic [N-1:0] sync_o, armed_o, done_o;

    int total = 0;
    int bad   = 0;

    trig_sync_arm #(.N_CH(N), .CNT_W(8), .PW_W(4)) dut (
        .sysClk     (sysClk),
        .reset      (reset),
        .arm_i      (arm_i),
        .disarm_i   (disarm_i),
        .trig_i     (trig_i),
        .skip_cnt_i (skip_cnt_i),
        .pulse_w_i  (pulse_w_i),
        .cont_i     (cont_i),
        .sync_o     (sync_o),
        .armed_o    (armed_o),
        .done_o     (done_o)
    );

    always #5 sysClk = ~sysClk;

    // Reference model, one entry per channel; states 0=idle 1=armed 2=fire.
    int       m_st   [N];
    int       m_cnt  [N];
    int       m_skip [N];
    int       m_w    [N];
    int       m_rem  [N];
    bit       m_cont [N];
    bit       m_done [N];
    bit       m_tq;
    logic [3*N-1:0] exp_q[$];

    int rises [N];
    int highs [N];
    logic [N-1:0] prev_sync;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit te;
        logic [N-1:0] es, ea, ed;
        te = trig_i & ~m_tq;
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                m_st[c] = 0; m_cnt[c] = 0; m_done[c] = 0; m_rem[c] = 0;
            end
            m_tq = 1'b1;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (disarm_i[c]) begin
                    m_st[c] = 0; m_cnt[c] = 0; m_done[c] = 0;
                end else if (m_st[c] == 2) begin
                    if (m_rem[c] == 0) begin
                        m_done[c] = 1;
                        m_cnt[c]  = 0;
                        m_st[c]   = m_cont[c] ? 1 : 0;
                    end else begin
                        m_rem[c]--;
                    end
                end else if (arm_i[c]) begin
                    m_skip[c] = skip_cnt_i; m_w[c] = pulse_w_i; m_cont[c] = cont_i[c];
                    m_cnt[c] = 0; m_done[c] = 0; m_st[c] = 1;
                end else if (m_st[c] == 1 && te) begin
                    if (m_cnt[c] == m_skip[c]) begin
                        m_st[c]  = 2;
                        m_rem[c] = (m_w[c] < 1 ? 1 : m_w[c]) - 1;
                    end else begin
                        m_cnt[c]++;
                    end
                end
            end
            m_tq = trig_i;
        end
        for (int c = 0; c < N; c++) begin
            es[c] = (m_st[c] == 2);
            ea[c] = (m_st[c] == 1);
            ed[c] = m_done[c];
        end
        exp_q.push_back({es, ea, ed});
    endtask

    task automatic tick();
        logic [3*N-1:0] e;
        model_step();
        @(posedge sysClk);
        #1;
        e = exp_q.pop_front();
        chk("sync",  32'(sync_o),  32'(e[3*N-1:2*N]));
        chk("armed", 32'(armed_o), 32'(e[2*N-1:N]));
        chk("done",  32'(done_o),  32'(e[N-1:0]));
        for (int c = 0; c < N; c++) begin
            if (sync_o[c] && !prev_sync[c]) rises[c]++;
            if (sync_o[c]) highs[c]++;
        end
        prev_sync = sync_o;
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < N; c++) begin
            rises[c] = 0; highs[c] = 0;
        end
    endtask

    task automatic edge_(input int lo, input int hi);
        trig_i = 1'b0;
        repeat (lo) tick();
        trig_i = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic arm_ch(input logic [N-1:0] m);
        arm_i = m;
        tick();
        arm_i = '0;
    endtask

    initial begin
        reset = 1'b1; arm_i = '0; disarm_i = '0; cont_i = '0;
        trig_i = 1'b1; skip_cnt_i = 8'd0; pulse_w_i = 4'd1;
        prev_sync = '0;
        clr_cnt();
        repeat (3) tick();
        chk("rst_sync", 32'(sync_o), 32'd0);
        chk("rst_armed", 32'(armed_o), 32'd0);

        // Trigger held high through reset release must not fire.
        reset = 1'b0;
        tick();
        arm_ch(4'b0100);
        repeat (20) tick();
        chk("held_hi_pulses", 32'(rises[2]), 32'd0);
        edge_(2, 5);
        chk("held_hi_after_edge", 32'(rises[2]), 32'd1);
        chk("held_hi_done", 32'(done_o[2]), 32'd1);

        // One-shot, fire on the 4th edge.
        skip_cnt_i = 8'd3; pulse_w_i = 4'd1; cont_i = '0;
        clr_cnt();
        arm_ch(4'b0001);
        repeat (5) edge_(3, 3);
        chk("oneshot_pulses", 32'(rises[0]), 32'd1);
        chk("oneshot_width", 32'(highs[0]), 32'd1);
        chk("oneshot_done", 32'(done_o[0]), 32'd1);
        chk("oneshot_armed", 32'(armed_o[0]), 32'd0);

        // Continuous mode with 3-cycle pulses, then disarm.
        skip_cnt_i = 8'd0; pulse_w_i = 4'd3; cont_i = 4'b0010;
        clr_cnt();
        arm_ch(4'b0010);
        repeat (3) edge_(5, 5);
        chk("cont_pulses", 32'(rises[1]), 32'd3);
        chk("cont_width", 32'(highs[1]), 32'd9);
        disarm_i = 4'b0010;
        tick();
        disarm_i = '0;
        clr_cnt();
        repeat (2) edge_(5, 5);
        chk("disarm_pulses", 32'(rises[1]), 32'd0);
        chk("disarm_armed", 32'(armed_o[1]), 32'd0);

        // Arm and disarm together leave the channel idle.
        cont_i = '0; pulse_w_i = 4'd1;
        arm_i = 4'b0001; disarm_i = 4'b0001;
        tick();
        arm_i = '0; disarm_i = '0;
        chk("arm_disarm_armed", 32'(armed_o[0]), 32'd0);

        // Arm coincident with an edge: that edge is not counted.
        skip_cnt_i = 8'd1;
        trig_i = 1'b0;
        tick();
        arm_i = 4'b0001; trig_i = 1'b1;
        tick();
        arm_i = '0;
        clr_cnt();
        edge_(3, 3);
        chk("arm_edge_first", 32'(rises[0]), 32'd0);
        edge_(3, 3);
        chk("arm_edge_second", 32'(rises[0]), 32'd1);

        // Re-arm after 2 of 3 edges restarts the count.
        skip_cnt_i = 8'd2;
        clr_cnt();
        arm_ch(4'b1000);
        repeat (2) edge_(3, 3);
        arm_ch(4'b1000);
        repeat (2) edge_(3, 3);
        chk("rearm_no_fire", 32'(rises[3]), 32'd0);
        edge_(3, 3);
        chk("rearm_fire", 32'(rises[3]), 32'd1);

        // Independent channels, then reset in the middle of a wide pulse.
        skip_cnt_i = 8'd0; pulse_w_i = 4'd8;
        arm_ch(4'b1000);
        skip_cnt_i = 8'd1; pulse_w_i = 4'd2;
        arm_ch(4'b0010);
        skip_cnt_i = 8'd3;
        clr_cnt();
        edge_(2, 1);
        chk("indep_ch3", 32'(rises[3]), 32'd1);
        chk("indep_ch1_wait", 32'(rises[1]), 32'd0);
        edge_(1, 1);
        chk("indep_ch1", 32'(rises[1]), 32'd1);
        chk("indep_ch3_high", 32'(sync_o[3]), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_sync", 32'(sync_o), 32'd0);
        chk("midrst_armed", 32'(armed_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trig_sync_arm.md
# trig_sync_arm

Multi-channel, parametrised trigger synchronizer for the timing/event path. Each channel is armed by a software reset/arm request. After arming, it counts rising edges of the shared machine trigger and emits a fixed-width synchronized pulse on the programmed edge. Channels run one-shot or continuous. Outputs feed downstream acquisition blocks that must start on a known trigger boundary after a user reset.

## Interface
- N_CH, 4: number of independent channels
- CNT_W, 8: width of the trigger-skip counter
- PW_W, 4: width of the output pulse-width field

- sysClk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock sysClk
- arm_i  in  N_CH  per-channel arm request, one-cycle pulse
- disarm_i  in  N_CH  per-channel abort, one-cycle pulse
- trig_i  in  1  shared trigger, level input; only rising edges are counted
- skip_cnt_i  in  CNT_W  channel fires on edge number skip_cnt_i+1 after arm
- pulse_w_i  in  PW_W  sync pulse width in cycles; 0 is treated as 1
- cont_i  in  N_CH  per-channel mode: 1 = continuous, 0 = one-shot
- sync_o  out  N_CH  synchronized trigger pulse, registered
- armed_o  out  N_CH  channel in ARMED state, registered
- done_o  out  N_CH  sticky "fired" flag; cleared by arm, disarm or reset

## Operation
- Edge detect:
  - trig_q is a register of trig_i; it resets to 1, so a trigger held high through reset is not an edge.
  - tedge = trig_i & ~trig_q. This single detector is shared by all channels.
- Per-channel FSM states are IDLE, ARMED and FIRE.
  - IDLE: on arm_i, latch skip_cnt_i, pulse_w_i and cont_i, clear count and done_o, then go to ARMED.
  - ARMED: on tedge, if count == skip_lat, go to FIRE, set sync_o=1, load pw counter with max(pulse_w_lat,1)-1. Otherwise count <= count+1.
  - FIRE: sync_o stays 1 until the pw counter reaches 0; then sync_o=0 and done_o=1.
    - If cont_lat=1, go to ARMED with count=0.
    - If cont_lat=0, go to IDLE.
- Config change after arm has no effect until the next arm.
- count never exceeds skip_lat, so there is no wrap.
- Boundary rules:
  - disarm_i in any state: go to IDLE, sync_o=0 next cycle, count cleared. disarm wins over a simultaneous arm_i.
  - arm_i while ARMED: re-latch config, restart count at 0. A tedge in the same cycle is not counted.
  - arm_i while FIRE: ignored. The pulse completes.
  - tedge during FIRE: ignored, not counted.
  - arm_i and tedge in the same cycle from IDLE: arm is taken, the edge is not counted.
  - Reset mid-pulse: sync_o drops on the next cycle.
- Reset values:
  - sync_o=0, armed_o=0, done_o=0.
  - All FSMs in IDLE, count=0, trig_q=1.

## Timing
- arm_i high at clock edge k: armed_o=1 from edge k+1.
- trig_i rises before edge t (sampled 1 at t, trig_q=0) with the matching count: sync_o=1 from t+1 through t+W, where W=max(pulse_w_lat,1).
- In continuous mode the channel is ARMED again at t+W+1 and can count an edge sampled at t+W+1.
- done_o rises at t+W+1.
- Latency from trigger sample to sync_o is 1 cycle. There are no combinational paths input to output.

## Structure
- Package trig_sync_pkg holds:
  - state enum: IDLE, ARMED, FIRE
  - default widths
  - MODE_ONESHOT and MODE_CONT constants
- Sub-module trig_sync_ch holds one channel FSM, its counters and latched config.
  - It is instantiated N_CH times via generate.
- The top level holds the shared edge detector and the fan-out.

## Test plan
- Backward compatibility: skip_cnt=3, pulse_w=1, one-shot, arm ch0, then 5 trigger edges. Required: one sync_o[0] pulse of 1 cycle, one cycle after edge 4; done_o[0]=1; armed_o[0]=0.
- Pulse width and continuous: skip_cnt=0, pulse_w=3, cont=1, edges every 10 cycles. Required: a 3-cycle pulse per edge. Then disarm. Required: no further pulses, armed_o=0.
- Trigger held high across reset: trig_i=1 through release of reset, arm, hold trig_i high 20 cycles. Required: no pulse. Then a low→high transition gives a pulse with skip_cnt=0.
- Simultaneous events:
  - arm and disarm same cycle: IDLE.
  - arm and edge same cycle: edge not counted; with skip_cnt=1, fire on the 2nd later edge.
  - Re-arm after 2 of 3 edges: count restarts.
- Channel independence and reset mid-pulse: arm ch1/ch3 with different skip_cnt latched at their own arm times; each fires on its own edge. Assert reset during a pulse_w=8 pulse. Required: sync_o=0 and all outputs 0 next cycle.
